nms_window_ctrl: RTL and testbench

//  Sequencer for the 3x3 non-maximum-suppression compare stage of the FAST corner pipeline.

---
 rtl/nms_window_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nms_window_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nms_window_ctrl.sv
// Window sequencer for the 3x3 NMS stage: buffers two score rows and one pixel row, builds the
// 3x3 score window, and registers the datapath verdict with the centre pixel and its coordinates.
module nms_window_ctrl #(
   parameter int IMG_W   = 160,
   parameter int IMG_H   = 120,
   parameter int PXL_W   = 8,
   parameter int SCORE_W = 12,
   parameter int X_W     = 8,
   parameter int Y_W     = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_sof,
   input  logic [PXL_W-1:0]   in_pxl,
   input  logic [SCORE_W-1:0] in_score,
   output logic [PXL_W-1:0]   nms_ref_pxl,
   output logic [SCORE_W-1:0] nms_ref_score,
   output logic [SCORE_W-1:0] nms_nigh_score0,
   output logic [SCORE_W-1:0] nms_nigh_score1,
   output logic [SCORE_W-1:0] nms_nigh_score2,
   output logic [SCORE_W-1:0] nms_nigh_score3,
   output logic [SCORE_W-1:0] nms_nigh_score4,
   output logic [SCORE_W-1:0] nms_nigh_score5,
   output logic [SCORE_W-1:0] nms_nigh_score6,
   output logic [SCORE_W-1:0] nms_nigh_score7,
   input  logic               nms_is_corner,
   output logic               out_valid,
   output logic               out_corner,
   output logic [PXL_W-1:0]   out_pxl,
   output logic [X_W-1:0]     out_x,
   output logic [Y_W-1:0]     out_y,
   output logic               frame_done,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t             stateReg, stateNext;
   logic [X_W-1:0]     colReg, colNext, curCol;
   logic [Y_W-1:0]     rowReg, rowNext, curRow;
   logic               accept, lastPixel, winFire;

   // Line buffers: row y-1 and y-2 scores, row y-1 pixels (read-before-write)
   logic [SCORE_W-1:0] scoreRow1 [IMG_W];
   logic [SCORE_W-1:0] scoreRow2 [IMG_W];
   logic [PXL_W-1:0]   pxlRow1   [IMG_W];
   logic [SCORE_W-1:0] rdScore1, rdScore2;
   logic [PXL_W-1:0]   rdPxl1;

   // win[r][c]: r=0 top row (y-2), r=2 incoming row; c=0 oldest column, c=2 newest
   logic [SCORE_W-1:0] win [3][3];
   logic [SCORE_W-1:0] newCol [3];
   logic [PXL_W-1:0]   pxlNew, pxlCtr;
   logic [X_W-1:0]     winX;
   logic [Y_W-1:0]     winY;
   logic               winValid;

   always_comb begin
      stateNext = stateReg;
      colNext   = colReg;
      rowNext   = rowReg;
      accept    = 1'b0;
      lastPixel = 1'b0;
      curCol    = in_sof ? '0 : colReg;
      curRow    = in_sof ? '0 : rowReg;
      if (in_valid && (in_sof || stateReg == ACTIVE)) begin
         accept    = 1'b1;
         stateNext = ACTIVE;
         if (curCol == X_W'(IMG_W-1)) begin
            colNext = '0;
            rowNext = curRow + Y_W'(1);
            if (curRow == Y_W'(IMG_H-1)) begin
               lastPixel = 1'b1;
               rowNext   = '0;
               stateNext = DONE;
            end
         end else begin
            colNext = curCol + X_W'(1);
            rowNext = curRow;
         end
      end else if (stateReg == DONE) begin
         stateNext = IDLE;
      end
   end

   assign winFire = accept && (curCol >= X_W'(2)) && (curRow >= Y_W'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg <= IDLE;
         colReg   <= '0;
         rowReg   <= '0;
      end else begin
         stateReg <= stateNext;
         colReg   <= colNext;
         rowReg   <= rowNext;
      end
   end

   assign rdScore1 = scoreRow1[curCol];
   assign rdScore2 = scoreRow2[curCol];
   assign rdPxl1   = pxlRow1[curCol];

   always_ff @(posedge clk) begin
      if (accept) begin
         scoreRow1[curCol] <= in_score;
         scoreRow2[curCol] <= rdScore1;
         pxlRow1[curCol]   <= in_pxl;
      end
   end

   assign newCol[0] = rdScore2;
   assign newCol[1] = rdScore1;
   assign newCol[2] = in_score;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) win[r][c] <= '0;
         end
         pxlNew   <= '0;
         pxlCtr   <= '0;
         winX     <= '0;
         winY     <= '0;
         winValid <= 1'b0;
      end else begin
         winValid <= winFire;
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
               win[r][2] <= newCol[r];
            end
            pxlNew <= rdPxl1;
            pxlCtr <= pxlNew;
            winX   <= curCol - X_W'(1);
            winY   <= curRow - Y_W'(1);
         end
      end
   end

   assign nms_ref_pxl     = pxlCtr;
   assign nms_ref_score   = win[1][1];
   assign nms_nigh_score0 = win[0][0];
   assign nms_nigh_score1 = win[0][1];
   assign nms_nigh_score2 = win[0][2];
   assign nms_nigh_score3 = win[1][2];
   assign nms_nigh_score4 = win[2][2];
   assign nms_nigh_score5 = win[2][1];
   assign nms_nigh_score6 = win[2][0];
   assign nms_nigh_score7 = win[1][0];

   // Result stage: the verdict is combinational on the window, so sample it one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_corner <= 1'b0;
         out_pxl    <= '0;
         out_x      <= '0;
         out_y      <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= winValid;
         frame_done <= lastPixel;
         if (winValid) begin
            out_corner <= nms_is_corner;
            out_pxl    <= pxlCtr;
            out_x      <= winX;
            out_y      <= winY;
         end
      end
   end

   assign busy = (stateReg == ACTIVE);

endmodule

// File: tb/tb_nms_window_ctrl.sv
// Scoreboard bench for nms_window_ctrl on a 5x5 frame; a threshold stub stands in for the
// compare datapath so that out_corner depends on the presented centre score.
module tb_nms_window_ctrl;
   localparam int W = 5, H = 5, PW = 8, SW = 12, XW = 3, YW = 3;
   localparam int THRESH = 18;

   logic clk, rst_n, in_valid, in_sof;
   logic [PW-1:0] in_pxl;
   logic [SW-1:0] in_score;
   logic [PW-1:0] nms_ref_pxl;
   logic [SW-1:0] nms_ref_score;
   logic [SW-1:0] n0, n1, n2, n3, n4, n5, n6, n7;
   logic nms_is_corner, out_valid, out_corner, frame_done, busy;
   logic [PW-1:0] out_pxl;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;

   nms_window_ctrl #(.IMG_W(W), .IMG_H(H), .PXL_W(PW), .SCORE_W(SW), .X_W(XW), .Y_W(YW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pxl(in_pxl),
      .in_score(in_score), .nms_ref_pxl(nms_ref_pxl), .nms_ref_score(nms_ref_score),
      .nms_nigh_score0(n0), .nms_nigh_score1(n1), .nms_nigh_score2(n2), .nms_nigh_score3(n3),
      .nms_nigh_score4(n4), .nms_nigh_score5(n5), .nms_nigh_score6(n6), .nms_nigh_score7(n7),
      .nms_is_corner(nms_is_corner), .out_valid(out_valid), .out_corner(out_corner),
      .out_pxl(out_pxl), .out_x(out_x), .out_y(out_y), .frame_done(frame_done), .busy(busy));

   assign nms_is_corner = (nms_ref_score >= SW'(THRESH));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [XW-1:0]   x;
      logic [YW-1:0]   y;
      logic            corner;
      logic [PW-1:0]   pxl;
      logic [SW-1:0]   refS;
      logic [8*SW-1:0] nigh;
      int              cyc;
   } exp_t;

   exp_t expQ[$];
   int   doneQ[$];
   int   cyc = 0;
   int   errors = 0, checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int scoreOf(int pat, int c, int r);
      case (pat)
         1: return r * 5 + c;
         2: return (c == 2 && r == 2) ? 100 : 0;
         4: return ((c == 0 && r == 2) || (c == 4 && r == 4)) ? 100 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int pxlOf(int pat, int c, int r);
      return (pat * 37 + r * 16 + c * 3 + 1) & 255;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic driveOne(int pat, int c, int r, bit sof);
      exp_t e;
      int dx[8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
      int dy[8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_sof   = sof;
      in_pxl   = PW'(pxlOf(pat, c, r));
      in_score = SW'(scoreOf(pat, c, r));
      if (c >= 2 && r >= 2) begin
         e.x      = XW'(c - 1);
         e.y      = YW'(r - 1);
         e.refS   = SW'(scoreOf(pat, c - 1, r - 1));
         e.corner = (scoreOf(pat, c - 1, r - 1) >= THRESH);
         e.pxl    = PW'(pxlOf(pat, c - 1, r - 1));
         e.nigh   = '0;
         for (int k = 0; k < 8; k++)
            e.nigh[k*SW +: SW] = SW'(scoreOf(pat, c - 1 + dx[k], r - 1 + dy[k]));
         e.cyc = cyc + 2;
         expQ.push_back(e);
      end
      if (c == W - 1 && r == H - 1) doneQ.push_back(cyc + 1);
   endtask

   task automatic idleCycle();
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_pxl   = PW'($urandom);
      in_score = SW'($urandom);
   endtask

   task automatic idleN(int n);
      for (int i = 0; i < n; i++) idleCycle();
   endtask

   task automatic sendFrame(int pat, bit gap, int stopAt);
      for (int i = 0; i < W * H; i++) begin
         if (i == stopAt) return;
         driveOne(pat, i % W, i / W, i == 0);
         if (gap) idleCycle();
      end
   endtask

   // Monitor: window snapshot from the previous negedge is what the result was computed from
   exp_t          monE;
   int            monD;
   logic [SW-1:0] snapRef;
   logic [PW-1:0] snapPxl;
   logic [8*SW-1:0] snapNigh;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) begin
            if (doneQ.size() == 0) begin
               checks++; errors++;
               $display("FAIL frame_done: got unexpected pulse expected none (cyc=%0d)", cyc);
            end else begin
               monD = doneQ.pop_front();
               chk("frame_done_cycle", cyc, monD);
               $display("frame_done at cyc=%0d", cyc);
            end
         end
         if (out_valid) begin
            $display("result x=%0d y=%0d corner=%0d pxl=%0h cyc=%0d", out_x, out_y, out_corner, out_pxl, cyc);
            chk("centre_interior", (out_x >= 1 && out_x <= W - 2 && out_y >= 1 && out_y <= H - 2), 1);
            if (expQ.size() == 0) begin
               checks++; errors++;
               $display("FAIL out_valid: got unexpected result x=%0d y=%0d expected none", out_x, out_y);
            end else begin
               monE = expQ.pop_front();
               chk("out_x", out_x, monE.x);
               chk("out_y", out_y, monE.y);
               chk("out_corner", out_corner, monE.corner);
               chk("out_pxl", out_pxl, monE.pxl);
               chk("nms_ref_pxl", snapPxl, monE.pxl);
               chk("nms_ref_score", snapRef, monE.refS);
               chk("nms_nigh", snapNigh, monE.nigh);
               chk("latency_cycle", cyc, monE.cyc);
            end
         end
      end
      snapRef  = nms_ref_score;
      snapPxl  = nms_ref_pxl;
      snapNigh = {n7, n6, n5, n4, n3, n2, n1, n0};
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pxl = '0; in_score = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_pxl", out_pxl, 0);
      chk("rst_nms_ref_score", nms_ref_score, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      sendFrame(1, 1'b0, -1);          // ramp, only (3,3) passes threshold
      idleN(6);
      chk("busy_after_frame", busy, 0);
      sendFrame(2, 1'b0, -1);          // single peak at (2,2)
      idleN(4);
      sendFrame(2, 1'b1, -1);          // same frame with in_valid toggling
      idleN(4);
      sendFrame(4, 1'b0, -1);          // peaks only on the border
      idleN(4);
      sendFrame(1, 1'b0, 12);          // aborted by in_sof at pixel 12
      sendFrame(1, 1'b0, -1);
      idleN(4);

      for (int i = 0; i < 5; i++) begin   // non-sof pixels in IDLE are dropped
         @(posedge clk); #1;
         in_valid = 1'b1; in_sof = 1'b0; in_pxl = PW'($urandom); in_score = 12'd999;
      end
      idleN(4);
      chk("busy_idle_drop", busy, 0);

      for (int i = 0; i <= 12; i++) driveOne(1, i % W, i / W, i == 0);
      idleCycle();
      @(posedge clk); #1;
      chk("pre_reset_out_valid", out_valid, 1);
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      expQ.delete();
      doneQ.delete();
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_x", out_x, 0);
      chk("mid_rst_out_y", out_y, 0);
      chk("mid_rst_out_pxl", out_pxl, 0);
      chk("mid_rst_nms_ref_score", nms_ref_score, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      sendFrame(1, 1'b0, -1);
      idleN(6);

      chk("pending_results", expQ.size(), 0);
      chk("pending_frame_done", doneQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
